// File: rtl/accum_pkg.sv
// Shared definitions for the block accumulator: per-beat operation codes
// and the two-state block sequencing FSM.
package accum_pkg;

  // Operation applied by each accepted operand beat
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_HOLD = 2'b11
  } op_t;

  // ACCUM collects beats; DUMP is the single cycle that publishes the total
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DUMP  = 1'b1
  } state_t;

endpackage

// File: rtl/adder_sub_N_bits.sv
// Combinational N-bit add/subtract unit. Produces the N-bit result, the
// unsigned carry (add) or borrow (sub), and the signed overflow flag.
module adder_sub_N_bits #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  logic [N:0] wide;

  // Widen by one bit so bit N is the carry on add and the borrow on sub
  // (an N+1-bit difference underflows exactly when b > a).
  always_comb begin
    wide     = '0;
    overflow = 1'b0;
    if (sub) begin
      wide     = {1'b0, a} - {1'b0, b};
      overflow = (a[N-1] != b[N-1]) && (wide[N-1] != a[N-1]);
    end else begin
      wide     = {1'b0, a} + {1'b0, b};
      overflow = (a[N-1] == b[N-1]) && (wide[N-1] != a[N-1]);
    end
    sum   = wide[N-1:0];
    carry = wide[N];
  end

endmodule

// File: rtl/accum_block_n_bits.sv
// Block accumulator: accepts operand beats over valid/ready, applies
// add/sub/load/hold, and after every DEPTH accepted beats publishes the
// block total for one cycle before restarting from zero.
// Optional feature: define ACCUM_SAT_EN to saturate S on signed overflow
// instead of wrapping modulo 2^N.
module accum_block_n_bits
  import accum_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    op,
  input  logic [N-1:0]  A,
  output logic [N-1:0]  S,
  output logic          carry,
  output logic          overflow,
  output logic [CW-1:0] count,
  output logic [N-1:0]  result,
  output logic          result_overflow,
  output logic          result_valid
);

  state_t       state;
  state_t       state_next;
  op_t          op_code;
  logic         accept;
  logic         last_beat;
  logic [N-1:0] as_sum;
  logic         as_carry;
  logic         as_ovf;
  logic [N-1:0] arith_value;

  assign op_code   = op_t'(op);
  assign in_ready  = (state == ST_ACCUM) && !reset;
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (count == CW'(DEPTH - 1));

  adder_sub_N_bits #(.N(N)) u_adder_sub (
    .a        (S),
    .b        (A),
    .sub      (op_code == OP_SUB),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );

`ifdef ACCUM_SAT_EN
  // Clamp toward the sign of S: overflow always pushes away from S's sign
  // for both add and subtract, so S's MSB picks the saturation rail.
  always_comb begin
    arith_value = as_sum;
    if (as_ovf) begin
      arith_value = S[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  assign arith_value = as_sum;
`endif

  // Block FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_ACCUM;
    else       state <= state_next;
  end

  // Next state: clear aborts anything; the DEPTH-th beat enters DUMP
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_ACCUM;
    end else begin
      case (state)
        ST_ACCUM: if (last_beat) state_next = ST_DUMP;
        ST_DUMP:  state_next = ST_ACCUM;
        default:  state_next = ST_ACCUM;
      endcase
    end
  end

  // Datapath: running value, flags, beat counter and published result
  always_ff @(posedge clk) begin
    if (reset) begin
      S               <= '0;
      carry           <= 1'b0;
      overflow        <= 1'b0;
      count           <= '0;
      result          <= '0;
      result_overflow <= 1'b0;
      result_valid    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clear) begin
        S        <= '0;
        carry    <= 1'b0;
        overflow <= 1'b0;
        count    <= '0;
      end else if (state == ST_DUMP) begin
        result          <= S;
        result_overflow <= overflow;
        result_valid    <= 1'b1;
        S               <= '0;
        carry           <= 1'b0;
        overflow        <= 1'b0;
      end else if (accept) begin
        count <= last_beat ? '0 : count + 1'b1;
        case (op_code)
          OP_ADD, OP_SUB: begin
            S     <= arith_value;
            carry <= as_carry;
            if (as_ovf) overflow <= 1'b1;
          end
          OP_LOAD: begin
            S     <= A;
            carry <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accum_block_n_bits.sv
// Directed self-checking bench for accum_block_n_bits with N=8, DEPTH=4.
// Expected values follow ACCUM_SAT_EN when the bench is built with it.
module tb_accum_block_n_bits;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH);

`ifdef ACCUM_SAT_EN
  localparam logic [7:0] EXP_ADD4  = 8'h7F;
  localparam logic [7:0] EXP_SUBOV = 8'h80;
`else
  localparam logic [7:0] EXP_ADD4  = 8'hA0;
  localparam logic [7:0] EXP_SUBOV = 8'h7F;
`endif

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_ready;
  logic [1:0]    op;
  logic [N-1:0]  A, S, result;
  logic          carry, overflow, result_overflow, result_valid;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  accum_block_n_bits #(.N(N), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .op              (op),
    .A               (A),
    .S               (S),
    .carry           (carry),
    .overflow        (overflow),
    .count           (count),
    .result          (result),
    .result_overflow (result_overflow),
    .result_valid    (result_valid)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a single beat for one edge, then drop valid
  task automatic beat(input logic [1:0] o, input logic [7:0] a);
    in_valid = 1'b1;
    op       = o;
    A        = a;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({S, carry, overflow, count, result, result_overflow, result_valid, in_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs S=%h c=%b ov=%b cnt=%0d res=%h rov=%b rv=%b rdy=%b expected all 0",
               S, carry, overflow, count, result, result_overflow, result_valid, in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add_block();
    logic [7:0] exp_s [4];
    exp_s[0] = 8'h10; exp_s[1] = 8'h30; exp_s[2] = 8'h60; exp_s[3] = EXP_ADD4;
    for (int i = 0; i < 4; i++) begin
      beat(2'b00, 8'(8'h10 * (i + 1)));
      checks++;
      if (S !== exp_s[i]) begin
        errors++;
        $display("[TB] FAIL add_S beat %0d got %h expected %h", i, S, exp_s[i]);
      end
    end
    checks++;
    if ({overflow, carry, count, in_ready} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_enter_dump ov=%b c=%b cnt=%0d rdy=%b expected ov=1 c=0 cnt=0 rdy=0",
               overflow, carry, count, in_ready);
    end
    tick();
    checks++;
    if ({result, result_overflow, result_valid, S, overflow, in_ready} !== {EXP_ADD4, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL add_dump res=%h rov=%b rv=%b S=%h ov=%b rdy=%b expected res=%h rov=1 rv=1 S=00 ov=0 rdy=1",
               result, result_overflow, result_valid, S, overflow, in_ready, EXP_ADD4);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_pulse_width rv=%b expected 0", result_valid);
    end
  endtask

  task automatic test_load_sub();
    beat(2'b10, 8'h05);
    beat(2'b01, 8'h07);
    checks++;
    if ({S, carry, overflow, count} !== {8'hFE, 1'b1, 1'b0, 2'd2}) begin
      errors++;
      $display("[TB] FAIL load_sub S=%h c=%b ov=%b cnt=%0d expected S=fe c=1 ov=0 cnt=2", S, carry, overflow, count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    beat(2'b10, 8'h80);
    beat(2'b01, 8'h01);
    checks++;
    if ({S, carry, overflow} !== {EXP_SUBOV, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL sub_overflow S=%h c=%b ov=%b expected S=%h c=0 ov=1", S, carry, overflow, EXP_SUBOV);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({S, carry, overflow, count, result} !== {8'h00, 1'b0, 1'b0, 2'd0, EXP_ADD4}) begin
      errors++;
      $display("[TB] FAIL clear_state S=%h c=%b ov=%b cnt=%0d res=%h expected S=00 c=0 ov=0 cnt=0 res=%h",
               S, carry, overflow, count, result, EXP_ADD4);
    end
  endtask

  task automatic test_hold_dump();
    in_valid = 1'b1;
    op       = 2'b11;
    A        = 8'h5A;
    repeat (4) tick();
    checks++;
    if ({count, in_ready, S} !== {2'd0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL hold_enter_dump cnt=%0d rdy=%b S=%h expected cnt=0 rdy=0 S=00", count, in_ready, S);
    end
    op = 2'b00;
    A  = 8'h11;
    tick();
    checks++;
    if ({result, result_valid, count, S} !== {8'h00, 1'b1, 2'd0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL hold_dump res=%h rv=%b cnt=%0d S=%h expected res=00 rv=1 cnt=0 S=00",
               result, result_valid, count, S);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({count, S, result_valid} !== {2'd1, 8'h11, 1'b0}) begin
      errors++;
      $display("[TB] FAIL held_beat cnt=%0d S=%h rv=%b expected cnt=1 S=11 rv=0", count, S, result_valid);
    end
  endtask

  task automatic test_clear_beat();
    beat(2'b00, 8'h22);
    clear    = 1'b1;
    in_valid = 1'b1;
    op       = 2'b00;
    A        = 8'h33;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({S, count, result, result_valid} !== {8'h00, 2'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL clear_with_beat S=%h cnt=%0d res=%h rv=%b expected S=00 cnt=0 res=00 rv=0",
               S, count, result, result_valid);
    end
  endtask

  task automatic test_clear_dump();
    repeat (4) beat(2'b00, 8'h01);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({result_valid, result, S, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b1}) begin
      errors++;
      $display("[TB] FAIL clear_in_dump rv=%b res=%h S=%h rdy=%b expected rv=0 res=00 S=00 rdy=1",
               result_valid, result, S, in_ready);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_in_dump_late rv=%b expected 0", result_valid);
    end
  endtask

  task automatic test_reset_mid();
    repeat (4) beat(2'b00, 8'h08);
    tick();
    beat(2'b00, 8'h44);
    beat(2'b11, 8'h00);
    beat(2'b11, 8'h00);
    checks++;
    if ({result, count, S} !== {8'h20, 2'd3, 8'h44}) begin
      errors++;
      $display("[TB] FAIL pre_reset res=%h cnt=%0d S=%h expected res=20 cnt=3 S=44", result, count, S);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({S, count, result, carry, overflow, result_overflow, result_valid, in_ready} !== {8'h00, 2'd0, 8'h00, 5'b00001}) begin
      errors++;
      $display("[TB] FAIL reset_mid S=%h cnt=%0d res=%h c=%b ov=%b rov=%b rv=%b rdy=%b expected zeros with rdy=1",
               S, count, result, carry, overflow, result_overflow, result_valid, in_ready);
    end
  endtask

  // Scenario sequence
  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    op       = 2'b00;
    A        = '0;
    test_reset();
    test_add_block();
    test_load_sub();
    test_hold_dump();
    test_clear_beat();
    test_clear_dump();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
